// File: rtl/alu.sv
// Execute-stage ALU: one-hot op decode, registered 16-bit result/flags, instruction pass-through.
// Latency 1 cycle, no stall; optional multiplier built only when ALU_MUL_EN is defined.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] alusignals,
  input  logic [15:0] instrin,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic [4:0]  immx,
  input  logic        isimmediate,
  output logic [15:0] aluresult,
  output logic [15:0] instrout,
  output logic        flag_eq,
  output logic        flag_gt
);

  logic [15:0] opb;
  logic [15:0] result_nxt;
  logic [15:0] product;
  logic        is_cmp;
  logic        shift_oor;

  assign opb       = isimmediate ? {{11{immx[4]}}, immx} : op2;
  assign shift_oor = |opb[15:4];

`ifdef ALU_MUL_EN
  assign product = op1 * opb;
`else
  assign product = 16'h0000;
`endif

  // Priority chain: the lowest-numbered set bit selects the op.
  always_comb begin
    result_nxt = 16'h0000;
    is_cmp     = 1'b0;
    if (alusignals[0] || alusignals[1] || alusignals[2]) begin
      result_nxt = op1 + opb;
    end else if (alusignals[3]) begin
      result_nxt = op1 - opb;
    end else if (alusignals[4]) begin
      result_nxt = product;
    end else if (alusignals[5]) begin
      is_cmp = 1'b1;
    end else if (alusignals[6]) begin
      result_nxt = opb;
    end else if (alusignals[7]) begin
      result_nxt = op1 | opb;
    end else if (alusignals[8]) begin
      result_nxt = op1 & opb;
    end else if (alusignals[9]) begin
      result_nxt = ~op1;
    end else if (alusignals[10]) begin
      result_nxt = shift_oor ? 16'h0000 : (op1 << opb[3:0]);
    end else if (alusignals[11]) begin
      result_nxt = shift_oor ? 16'h0000 : (op1 >> opb[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluresult <= 16'h0000;
      instrout  <= 16'h0000;
      flag_eq   <= 1'b0;
      flag_gt   <= 1'b0;
    end else begin
      aluresult <= result_nxt;
      instrout  <= instrin;
      if (is_cmp) begin
        flag_eq <= (op1 == opb);
        flag_gt <= ($signed(op1) > $signed(opb));
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of alu against a plain-arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] alusignals;
  logic [15:0] instrin, op1, op2;
  logic [4:0]  immx;
  logic        isimmediate;
  logic [15:0] aluresult, instrout;
  logic        flag_eq, flag_gt;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_res, exp_instr;
  logic        exp_eq, exp_gt;

  alu dut (
    .clk(clk), .rst_n(rst_n), .alusignals(alusignals), .instrin(instrin),
    .op1(op1), .op2(op2), .immx(immx), .isimmediate(isimmediate),
    .aluresult(aluresult), .instrout(instrout), .flag_eq(flag_eq), .flag_gt(flag_gt)
  );

  always #5 clk = ~clk;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lowest_bit(input logic [11:0] s);
    for (int i = 0; i < 12; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic int to_signed16(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  // Apply one op, advance a clock, then check every output against the model.
  task automatic apply(input string tag, input logic [11:0] s, input logic [15:0] ins,
                       input logic [15:0] a, input logic [15:0] o2,
                       input logic [4:0] im, input logic ism);
    longint ua, ub, r;
    int k;
    alusignals = s; instrin = ins; op1 = a; op2 = o2; immx = im; isimmediate = ism;
    ua = longint'(a);
    ub = ism ? (im[4] ? longint'(im) + 65504 : longint'(im)) : longint'(o2);
    k = lowest_bit(s);
    r = 0;
    case (k)
      0, 1, 2: r = ua + ub;
      3:       r = ua - ub + 65536;
      4:       r = MUL_ON ? ua * ub : 0;
      6:       r = ub;
      7:       r = longint'(a | ub[15:0]);
      8:       r = longint'(a & ub[15:0]);
      9:       r = 65535 - ua;
      10:      r = (ub >= 16) ? 0 : ua * (longint'(1) << ub);
      11:      r = (ub >= 16) ? 0 : ua / (longint'(1) << ub);
      default: r = 0;
    endcase
    if (k == 5) begin
      exp_eq = (ua == ub);
      exp_gt = to_signed16(a) > to_signed16(ub[15:0]);
    end
    exp_res = r[15:0];
    exp_instr = ins;
    @(posedge clk);
    #1;
    chk({tag, ".res"},   aluresult, exp_res);
    chk({tag, ".instr"}, instrout, exp_instr);
    chk({tag, ".eq"},    {15'd0, flag_eq}, {15'd0, exp_eq});
    chk({tag, ".gt"},    {15'd0, flag_gt}, {15'd0, exp_gt});
  endtask

  initial begin
    rst_n = 1'b0;
    alusignals = 12'h001; instrin = 16'h1234; op1 = 16'h7777; op2 = 16'h1111;
    immx = 5'h0A; isimmediate = 1'b0;
    exp_eq = 1'b0; exp_gt = 1'b0;
    #1;
    chk("rst_res",   aluresult, 16'h0000);
    chk("rst_instr", instrout, 16'h0000);
    chk("rst_flags", {14'd0, flag_eq, flag_gt}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", aluresult, 16'h0000);
    rst_n = 1'b1;

    apply("add", 12'h001, 16'h0001, 16'h0001, 16'h0005, 5'h00, 1'b0);
    chk("add_c", aluresult, 16'h0006);
    apply("ld",  12'h002, 16'h0002, 16'h0010, 16'h0005, 5'h00, 1'b0);
    chk("ld_c", aluresult, 16'h0015);
    apply("sub", 12'h008, 16'h0003, 16'h000A, 16'h0003, 5'h00, 1'b0);
    chk("sub_c", aluresult, 16'h0007);
    apply("mul", 12'h010, 16'h0004, 16'h0003, 16'h0002, 5'h00, 1'b0);
    chk("mul_c", aluresult, MUL_ON ? 16'h0006 : 16'h0000);
    apply("or",  12'h080, 16'h0005, 16'h0F0F, 16'h00FF, 5'h00, 1'b0);
    chk("or_c", aluresult, 16'h0FFF);
    apply("and", 12'h100, 16'h0006, 16'h00FF, 16'h0F0F, 5'h00, 1'b0);
    chk("and_c", aluresult, 16'h000F);
    apply("not", 12'h200, 16'h0007, 16'h00FF, 16'h0000, 5'h00, 1'b0);
    chk("not_c", aluresult, 16'hFF00);
    apply("lsl", 12'h400, 16'h0008, 16'h000F, 16'h0002, 5'h00, 1'b0);
    chk("lsl_c", aluresult, 16'h003C);
    apply("lsr", 12'h800, 16'h0009, 16'h000F, 16'h0002, 5'h00, 1'b0);
    chk("lsr_c", aluresult, 16'h0003);
    apply("lsl16", 12'h400, 16'h000A, 16'hFFFF, 16'h0010, 5'h00, 1'b0);
    chk("lsl16_c", aluresult, 16'h0000);
    apply("cmp_eq", 12'h020, 16'h000B, 16'h000F, 16'h000F, 5'h00, 1'b0);
    chk("cmp_eq_c", {14'd0, flag_eq, flag_gt}, 16'h0002);
    apply("hold", 12'h001, 16'h000C, 16'h0003, 16'h0004, 5'h00, 1'b0);
    chk("hold_c", {14'd0, flag_eq, flag_gt}, 16'h0002);
    apply("cmp_gt", 12'h020, 16'h000D, 16'h0001, 16'hFFFF, 5'h00, 1'b0);
    chk("cmp_gt_c", {14'd0, flag_eq, flag_gt}, 16'h0001);
    apply("imm_add", 12'h001, 16'h000E, 16'h0001, 16'h1234, 5'h1F, 1'b1);
    chk("imm_add_c", aluresult, 16'h0000);
    apply("imm_mov", 12'h040, 16'h000F, 16'h9999, 16'h1234, 5'h05, 1'b1);
    chk("imm_mov_c", aluresult, 16'h0005);
    apply("pass", 12'h000, 16'hABCD, 16'h1111, 16'h2222, 5'h00, 1'b0);
    chk("pass_c", instrout, 16'hABCD);
    chk("none_c", aluresult, 16'h0000);
    apply("multi", 12'h009, 16'h0010, 16'h0004, 16'h0001, 5'h00, 1'b0);
    chk("multi_c", aluresult, 16'h0005);

    for (int n = 0; n < 300; n++) begin
      logic [11:0] s;
      logic [15:0] b;
      case ($urandom_range(0, 9))
        0:       s = 12'h000;
        1:       s = 12'($urandom);
        default: s = 12'h001 << $urandom_range(0, 11);
      endcase
      b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3)) << 14 | 16'h0005;
      apply("rand", s, 16'($urandom), 16'($urandom), b, 5'($urandom), 1'($urandom));
    end

    // Reset asserted mid-stream must clear outputs without waiting for an edge.
    apply("pre_rst", 12'h020, 16'h5555, 16'h0009, 16'h0009, 5'h00, 1'b0);
    rst_n = 1'b0;
    exp_eq = 1'b0; exp_gt = 1'b0;
    #1;
    chk("mid_rst_res",   aluresult, 16'h0000);
    chk("mid_rst_instr", instrout, 16'h0000);
    chk("mid_rst_flags", {14'd0, flag_eq, flag_gt}, 16'h0000);
    #2;
    rst_n = 1'b1;
    apply("post_rst", 12'h001, 16'h0F0F, 16'h0001, 16'h0005, 5'h00, 1'b0);
    chk("post_rst_c", aluresult, 16'h0006);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
